hazard_ctrl: RTL

//  Pipeline sequencer that sits beside the forwarding unit in the 5-stage pipeline CPU.

---
 rtl/pipe_pkg.sv | 10 +
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the hazard sequencer state encoding.
package pipe_pkg;
  localparam logic [2:0] PCSRC_JR = 3'b011;
  localparam logic [4:0] REG_ZERO = 5'h00;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard sequencer bundle: pipeline-register fields in, stall/flush controls out.
// slave = hazard_ctrl side, master = pipeline / mult-div side.
interface hazard_ctrl_if;
  logic [4:0] IF_ID_Rs;
  logic [4:0] IF_ID_Rt;
  logic       IF_ID_MdUse;
  logic [2:0] ID_PCSrc;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_AddrC;
  logic       ID_EX_MdOp;
  logic       EX_MEM_MemRead;
  logic [4:0] EX_MEM_AddrC;
  logic       EX_BranchTaken;
  logic       md_done;
  logic       md_start;
  logic       PC_Write;
  logic       IF_ID_Write;
  logic       IF_ID_Flush;
  logic       ID_EX_Flush;
  logic       ID_EX_Hold;
  logic       EX_MEM_Flush;

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, IF_ID_MdUse, ID_PCSrc, ID_EX_MemRead, ID_EX_AddrC,
           ID_EX_MdOp, EX_MEM_MemRead, EX_MEM_AddrC, EX_BranchTaken, md_done,
    output md_start, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold,
           EX_MEM_Flush
  );

  modport master (
    output IF_ID_Rs, IF_ID_Rt, IF_ID_MdUse, ID_PCSrc, ID_EX_MemRead, ID_EX_AddrC,
           ID_EX_MdOp, EX_MEM_MemRead, EX_MEM_AddrC, EX_BranchTaken, md_done,
    input  md_start, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold,
           EX_MEM_Flush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stalls/flushes for load-use, JR-on-load, taken branches and
// mult/div occupancy. Outputs are combinational from FSM state plus inputs.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import pipe_pkg::*;
`ifdef HAZARD_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  md_state_t state, state_nxt;
  logic lu, jl, busy, fs, eh;
  logic md_start, pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_flush;

  // State register; reset abandons any in-flight mult/div tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Hazard detection, output priority (branch > EX hold > front stall) and next state.
  always_comb begin
    state_nxt    = state;
    md_start     = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    ex_mem_flush = 1'b0;
    busy = (state == MD_BUSY);
    lu   = hz.ID_EX_MemRead && (hz.ID_EX_AddrC != REG_ZERO) &&
           ((hz.ID_EX_AddrC == hz.IF_ID_Rs) || (hz.ID_EX_AddrC == hz.IF_ID_Rt));
    jl   = (hz.ID_PCSrc == PCSRC_JR) && hz.EX_MEM_MemRead &&
           (hz.EX_MEM_AddrC != REG_ZERO) && (hz.EX_MEM_AddrC == hz.IF_ID_Rs);
    fs   = lu || jl || (busy && hz.IF_ID_MdUse);
    eh   = busy && hz.ID_EX_MdOp;
    // Outputs sit at their reset values for as long as reset is held.
    if (!reset) begin
      md_start = !busy && hz.ID_EX_MdOp;
      if (hz.EX_BranchTaken) begin
        // Wrong-path instructions in IF/ID die; the older op in EX proceeds.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (eh) begin
        // A second mult/div waits in EX; ID_EX must hold, not bubble.
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_hold   = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (fs) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
      case (state)
        IDLE:    if (md_start)   state_nxt = MD_BUSY;
        MD_BUSY: if (hz.md_done) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign hz.md_start     = md_start;
  assign hz.PC_Write     = pc_write;
  assign hz.IF_ID_Write  = if_id_write;
  assign hz.IF_ID_Flush  = if_id_flush;
  assign hz.ID_EX_Flush  = id_ex_flush;
  assign hz.ID_EX_Hold   = id_ex_hold;
  assign hz.EX_MEM_Flush = ex_mem_flush;

`ifdef HAZARD_PERF_CNT_EN
  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (!pc_write && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end
`endif

endmodule
